// File: rtl/speaker_audio_rx.sv
// Mixes the Apple II speaker click with the Mockingboard levels into 16-bit stereo
// samples, paced by a fixed divider from clk_pixel_w that strobes the HDMI audio path.
module speaker_audio_rx #(
    parameter int          PIXEL_CLOCK_HZ    = 27_000_000,
    parameter int          AUDIO_RATE        = 44100,
    parameter int          HOLD_SAMPLES      = 255,
    parameter logic [15:0] SPEAKER_AMPLITUDE = 16'h2000,
    parameter int          ENABLE            = 1
) (
    input  logic        clk_pixel_w,
    input  logic        system_reset_n_w,
    input  logic        speaker_toggle_i,
    input  logic [9:0]  mb_audio_l_i,
    input  logic [9:0]  mb_audio_r_i,
    output logic [15:0] sample_l_o,
    output logic [15:0] sample_r_o,
    output logic        clk_audio_o,
    output logic        dbg_active_o,
    output logic [7:0]  dbg_hold_o
);
    localparam int CNT   = PIXEL_CLOCK_HZ / AUDIO_RATE;
    localparam int CNT_W = (CNT > 1) ? $clog2(CNT) : 1;
    localparam logic [7:0] HOLD_8 = 8'(HOLD_SAMPLES);

    typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick;
    logic             spk_s1_q, spk_s2_q, spk_s3_q;
    logic             edge_det;
    logic             pend_q, pend_d;
    logic [9:0]       mbl_s1_q, mbl_s2_q, mbr_s1_q, mbr_s2_q;
    state_t           state_q, state_d;
    logic [7:0]       hold_q, hold_d;
    logic             spk_on_q, spk_on_d;
    logic             tick_p1_q, tick_p2_q;
    logic             strobe_q;
    logic [15:0]      sample_l_q, sample_l_d, sample_r_q, sample_r_d;

    function automatic logic [15:0] mix(input logic [9:0] mb, input logic on);
        logic [16:0] sum;
        sum = {1'b0, mb, 4'b0000} + {1'b0, (on ? SPEAKER_AMPLITUDE : 16'h0000)};
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

    assign tick     = (cnt_q == CNT_W'(CNT - 1));
    assign cnt_d    = tick ? '0 : cnt_q + CNT_W'(1);
    assign edge_det = spk_s2_q ^ spk_s3_q;
    // An edge landing on the tick cycle must survive the clear so the next tick reports it.
    assign pend_d   = edge_det | (pend_q & ~tick);

    // FSM state register
    always_ff @(posedge clk_pixel_w or negedge system_reset_n_w) begin
        if (!system_reset_n_w) begin
            state_q <= IDLE;
            hold_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
        end
    end

    // FSM next state: moves only on ticks
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        if (tick) begin
            case (state_q)
                IDLE: begin
                    if (pend_q) begin
                        hold_d  = HOLD_8;
                        state_d = ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (pend_q) begin
                        hold_d = HOLD_8;
                    end else if (hold_q > 8'd1) begin
                        hold_d = hold_q - 8'd1;
                    end else begin
                        hold_d  = 8'h00;
                        state_d = IDLE;
                    end
                end
                default: begin
                    hold_d  = 8'h00;
                    state_d = IDLE;
                end
            endcase
        end
    end

    // FSM output: speaker term latched at the tick from the post-tick state
    always_comb begin
        spk_on_d = spk_on_q;
        if (tick) begin
            spk_on_d = (ENABLE != 0) && (state_d == ACTIVE) && spk_s2_q;
        end
    end

    always_comb begin
        sample_l_d = sample_l_q;
        sample_r_d = sample_r_q;
        if (tick_p1_q) begin
            sample_l_d = mix(mbl_s2_q, spk_on_q);
            sample_r_d = mix(mbr_s2_q, spk_on_q);
        end
    end

    // Samples update one cycle after the tick; the strobe follows one cycle later.
    always_ff @(posedge clk_pixel_w or negedge system_reset_n_w) begin
        if (!system_reset_n_w) begin
            cnt_q      <= '0;
            spk_s1_q   <= 1'b0;
            spk_s2_q   <= 1'b0;
            spk_s3_q   <= 1'b0;
            pend_q     <= 1'b0;
            mbl_s1_q   <= 10'h000;
            mbl_s2_q   <= 10'h000;
            mbr_s1_q   <= 10'h000;
            mbr_s2_q   <= 10'h000;
            spk_on_q   <= 1'b0;
            tick_p1_q  <= 1'b0;
            tick_p2_q  <= 1'b0;
            strobe_q   <= 1'b0;
            sample_l_q <= 16'h0000;
            sample_r_q <= 16'h0000;
        end else begin
            cnt_q      <= cnt_d;
            spk_s1_q   <= speaker_toggle_i;
            spk_s2_q   <= spk_s1_q;
            spk_s3_q   <= spk_s2_q;
            pend_q     <= pend_d;
            mbl_s1_q   <= mb_audio_l_i;
            mbl_s2_q   <= mbl_s1_q;
            mbr_s1_q   <= mb_audio_r_i;
            mbr_s2_q   <= mbr_s1_q;
            spk_on_q   <= spk_on_d;
            tick_p1_q  <= tick;
            tick_p2_q  <= tick_p1_q;
            strobe_q   <= tick_p2_q;
            sample_l_q <= sample_l_d;
            sample_r_q <= sample_r_d;
        end
    end

    assign sample_l_o   = sample_l_q;
    assign sample_r_o   = sample_r_q;
    assign clk_audio_o  = strobe_q;
    assign dbg_active_o = (state_q == ACTIVE);
    assign dbg_hold_o   = hold_q;

endmodule

// File: tb/tb_speaker_audio_rx.sv
// Bench for speaker_audio_rx: an index-based model of the tick/hold rules checked every
// cycle on a fast-divider instance, plus literal checks on default, saturating and disabled instances.
module tb_speaker_audio_rx;
    localparam int          AR   = 44100;
    localparam int          CNT  = 20;
    localparam int          PIX  = CNT * AR;
    localparam int          HOLD = 255;
    localparam logic [15:0] AMP  = 16'h2000;
    localparam int          MAXN = 40000;
    localparam int          BIG  = 1 << 30;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b1;
    logic       tog    = 1'b0;
    logic [9:0] mb_l   = 10'h000;
    logic [9:0] mb_r   = 10'h000;
    logic       cmp_en = 1'b0;

    logic [15:0] sl, sr, d_l, d_r, s_l, s_r, x_l, x_r;
    logic        strobe, d_strobe, s_strobe, x_strobe;
    logic        act, d_act, s_act, x_act;
    logic [7:0]  hold, d_hold, s_hold, x_hold;

    always #5 clk = ~clk;

    speaker_audio_rx #(.PIXEL_CLOCK_HZ(PIX), .AUDIO_RATE(AR), .HOLD_SAMPLES(HOLD),
                       .SPEAKER_AMPLITUDE(AMP), .ENABLE(1)) u_dut (
        .clk_pixel_w(clk), .system_reset_n_w(rst_n), .speaker_toggle_i(tog),
        .mb_audio_l_i(mb_l), .mb_audio_r_i(mb_r), .sample_l_o(sl), .sample_r_o(sr),
        .clk_audio_o(strobe), .dbg_active_o(act), .dbg_hold_o(hold));

    speaker_audio_rx u_def (
        .clk_pixel_w(clk), .system_reset_n_w(rst_n), .speaker_toggle_i(tog),
        .mb_audio_l_i(mb_l), .mb_audio_r_i(mb_r), .sample_l_o(d_l), .sample_r_o(d_r),
        .clk_audio_o(d_strobe), .dbg_active_o(d_act), .dbg_hold_o(d_hold));

    speaker_audio_rx #(.PIXEL_CLOCK_HZ(PIX), .AUDIO_RATE(AR), .HOLD_SAMPLES(HOLD),
                       .SPEAKER_AMPLITUDE(16'hF000), .ENABLE(1)) u_sat (
        .clk_pixel_w(clk), .system_reset_n_w(rst_n), .speaker_toggle_i(tog),
        .mb_audio_l_i(mb_l), .mb_audio_r_i(mb_r), .sample_l_o(s_l), .sample_r_o(s_r),
        .clk_audio_o(s_strobe), .dbg_active_o(s_act), .dbg_hold_o(s_hold));

    speaker_audio_rx #(.PIXEL_CLOCK_HZ(PIX), .AUDIO_RATE(AR), .HOLD_SAMPLES(HOLD),
                       .SPEAKER_AMPLITUDE(AMP), .ENABLE(0)) u_dis (
        .clk_pixel_w(clk), .system_reset_n_w(rst_n), .speaker_toggle_i(tog),
        .mb_audio_l_i(mb_l), .mb_audio_r_i(mb_r), .sample_l_o(x_l), .sample_r_o(x_r),
        .clk_audio_o(x_strobe), .dbg_active_o(x_act), .dbg_hold_o(x_hold));

    int vec_cnt = 0;
    int err_cnt = 0;

    task automatic check(input string name, input int actual, input int expected);
        vec_cnt++;
        if (actual !== expected) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // ---------------- model ----------------
    // hist[i] holds the input value present between edge i and edge i+1 after reset release.
    logic        tog_hist[MAXN];
    logic [9:0]  mbl_hist[MAXN];
    logic [9:0]  mbr_hist[MAXN];
    int          n = 0;
    int          since = BIG;
    logic [15:0] pend_l = 16'h0, pend_r = 16'h0, exp_l = 16'h0, exp_r = 16'h0;
    logic        exp_strobe = 1'b0, exp_active = 1'b0;
    logic [7:0]  exp_hold = 8'h0;

    function automatic logic tog_at(input int i);
        return (i < 0) ? 1'b0 : tog_hist[i];
    endfunction

    function automatic logic [9:0] mbl_at(input int i);
        return (i < 0) ? 10'h0 : mbl_hist[i];
    endfunction

    function automatic logic [9:0] mbr_at(input int i);
        return (i < 0) ? 10'h0 : mbr_hist[i];
    endfunction

    function automatic logic [15:0] mix(input logic [9:0] mb, input logic on);
        int s;
        s = int'(mb) * 16 + (on ? int'(AMP) : 0);
        return (s > 65535) ? 16'hFFFF : 16'(s);
    endfunction

    // Tick k lands on edge k*CNT. A toggle driven in slot e is seen by the first tick at
    // edge >= e+4; the level read at tick edge E is the one driven in slot E-3.
    initial begin
        logic pending;
        logic on;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                n = 0; since = BIG;
                pend_l = 16'h0; pend_r = 16'h0; exp_l = 16'h0; exp_r = 16'h0;
                exp_strobe = 1'b0; exp_active = 1'b0; exp_hold = 8'h0;
            end else begin
                n++;
                if (n <= MAXN) begin
                    tog_hist[n-1] = tog;
                    mbl_hist[n-1] = mb_l;
                    mbr_hist[n-1] = mb_r;
                end
                exp_strobe = (n > 2) && (n % CNT == 2);
                if (n > 1 && n % CNT == 1) begin
                    exp_l = pend_l;
                    exp_r = pend_r;
                end
                if (n % CNT == 0) begin
                    pending = 1'b0;
                    for (int i = n - CNT - 3; i <= n - 4; i++)
                        if (tog_at(i) != tog_at(i - 1)) pending = 1'b1;
                    if (pending) since = 0;
                    else if (since < BIG) since++;
                    exp_active = (since < HOLD);
                    exp_hold   = exp_active ? 8'(HOLD - since) : 8'h0;
                    on         = exp_active && tog_at(n - 3);
                    pend_l     = mix(mbl_at(n - 2), on);
                    pend_r     = mix(mbr_at(n - 2), on);
                end
            end
        end
    end

    // Per-cycle compare of the fast instance against the model.
    initial begin
        logic [15:0] el, er;
        logic        es, ea;
        logic [7:0]  eh;
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                if (!rst_n) begin
                    el = 16'h0; er = 16'h0; es = 1'b0; ea = 1'b0; eh = 8'h0;
                end else begin
                    el = exp_l; er = exp_r; es = exp_strobe; ea = exp_active; eh = exp_hold;
                end
                vec_cnt++;
                if (sl !== el || sr !== er || strobe !== es || act !== ea || hold !== eh) begin
                    err_cnt++;
                    $display("FAIL model n=%0d: got l=%h r=%h stb=%b act=%b hold=%0d, expected l=%h r=%h stb=%b act=%b hold=%0d",
                             n, sl, sr, strobe, act, hold, el, er, es, ea, eh);
                end
            end
        end
    end

    // ---------------- directed sequence ----------------
    task automatic wait_strobe();
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 3 * CNT && !seen; i++) begin
            @(negedge clk);
            if (strobe) seen = 1'b1;
        end
        if (!seen) begin
            vec_cnt++;
            err_cnt++;
            $display("FAIL strobe_timeout: got no strobe, expected one within %0d cycles", 3 * CNT);
        end
    endtask

    initial begin
        int  k;
        logic found;
        logic saw;

        #1 rst_n = 1'b0;
        cmp_en = 1'b1;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;

        // Default divider: first strobe 614 cycles after release, then every 612.
        found = 1'b0; k = -1;
        for (int i = 1; i <= 700 && !found; i++) begin
            @(negedge clk);
            if (d_strobe) begin found = 1'b1; k = i; end
        end
        check("def_first_strobe_cycle", k, 614);
        found = 1'b0; k = -1;
        for (int i = 1; i <= 700 && !found; i++) begin
            @(negedge clk);
            if (d_strobe) begin found = 1'b1; k = i; end
        end
        check("def_strobe_period", k, 612);
        check("def_sample_l_idle", int'(d_l), 0);
        check("def_sample_r_idle", int'(d_r), 0);

        // Mockingboard only
        wait_strobe();
        mb_l = 10'h3FF; mb_r = 10'h001;
        wait_strobe();
        wait_strobe();
        check("mb_only_l", int'(sl), 16'h3FF0);
        check("mb_only_r", int'(sr), 16'h0010);

        // Toggle whose edge detect lands on the tick cycle: reported one tick later.
        wait_strobe();
        repeat (CNT - 5) @(negedge clk);
        tog = 1'b1;
        wait_strobe();
        check("coinc_not_yet_l", int'(sl), 16'h3FF0);
        check("coinc_not_yet_active", int'(act), 0);
        wait_strobe();
        check("coinc_late_l", int'(sl), 16'h5FF0);
        check("coinc_late_r", int'(sr), 16'h2010);
        check("sat_l", int'(s_l), 16'hFFFF);
        check("sat_r", int'(s_r), 16'hF010);
        check("disabled_l", int'(x_l), 16'h3FF0);

        // Toggle every 100 ticks keeps the block active.
        for (int r = 0; r < 3; r++) begin
            repeat (100) wait_strobe();
            check("keepalive_active", int'(act), 1);
            if (r == 1) begin mb_l = 10'h155; mb_r = 10'h2AA; end
            if (r == 2) begin mb_l = 10'h3FF; mb_r = 10'h001; end
            tog = ~tog;
        end
        wait_strobe();
        check("keepalive_level_low_l", int'(sl), 16'h3FF0);

        // Single rising toggle held high: 255 ticks of speaker term, then idle.
        repeat (99) wait_strobe();
        tog = 1'b1;
        wait_strobe();
        check("rise_next_l", int'(sl), 16'h5FF0);
        check("rise_next_r", int'(sr), 16'h2010);
        repeat (254) wait_strobe();
        check("hold_last_on_l", int'(sl), 16'h5FF0);
        check("hold_last_on_hold", int'(hold), 1);
        wait_strobe();
        check("hold_expired_l", int'(sl), 16'h3FF0);
        check("hold_expired_active", int'(act), 0);

        // Reset in the middle of ACTIVE
        wait_strobe();
        tog = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 5000 && !found; i++) begin
            @(negedge clk);
            if (hold == 8'd100) found = 1'b1;
        end
        check("reached_hold_100", int'(found), 1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_sample_l", int'(sl), 0);
        check("rst_sample_r", int'(sr), 0);
        check("rst_active", int'(act), 0);
        check("rst_hold", int'(hold), 0);
        saw = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (strobe) saw = 1'b1;
        end
        check("no_strobe_in_reset", int'(saw), 0);
        rst_n = 1'b1;
        found = 1'b0; k = -1;
        for (int i = 1; i <= 3 * CNT && !found; i++) begin
            @(negedge clk);
            if (strobe) begin found = 1'b1; k = i; end
        end
        check("post_reset_strobe_cycle", k, CNT + 2);
        check("post_reset_sample_l", int'(sl), 16'h3FF0);
        repeat (3) wait_strobe();

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/speaker_audio_rx.md
SPEAKER_AUDIO_RX -- requirements
Module: speaker_audio_rx

Interface
REQ-001 The module SHALL have parameter PIXEL_CLOCK_HZ, default 27_000_000, meaning the clk_pixel_w frequency in Hz.
REQ-002 The module SHALL have parameter AUDIO_RATE, default 44100, meaning the output sample rate in Hz.
REQ-003 The module SHALL have parameter HOLD_SAMPLES, default 255, meaning the number of sample ticks the speaker pulse may persist after the last toggle.
REQ-004 The module SHALL have parameter SPEAKER_AMPLITUDE, default 16'h2000, meaning the value added to each channel while the speaker is on.
REQ-005 The module SHALL have parameter ENABLE, default 1, meaning speaker contribution is enabled; 0 forces the speaker term to zero.
REQ-006 The module SHALL have port clk_pixel_w, input, 1 bit, the sole clock.
REQ-007 The module SHALL have port system_reset_n_w, input, 1 bit, asynchronous active-low reset.
REQ-008 The module SHALL have port speaker_toggle_i, input, 1 bit, the speaker level from the clk_logic domain, asynchronous to clk_pixel_w.
REQ-009 The module SHALL have ports mb_audio_l_i and mb_audio_r_i, input, 10 bits each, unsigned Mockingboard levels from the clk_logic domain.
REQ-010 The module SHALL have ports sample_l_o and sample_r_o, output, 16 bits each, the registered mixed audio samples.
REQ-011 The module SHALL have port clk_audio_o, output, 1 bit, a one-cycle sample strobe for the HDMI audio input.

Function
REQ-012 The module SHALL define CNT = PIXEL_CLOCK_HZ / AUDIO_RATE (integer division; 612 at defaults); the divider counts 0..CNT-1, wraps to 0, and asserts the internal tick for exactly one cycle when the count is CNT-1.
REQ-013 The module SHALL pass speaker_toggle_i through a 2-flop synchronizer, then a third register, and detect an edge as the XOR of the last two stages.
REQ-014 The module SHALL set a sticky edge_pending flag on a detected edge and clear it on a tick; an edge and a tick in the same cycle SHALL leave edge_pending set so that the edge is reported on the next tick.
REQ-015 The module SHALL double-register mb_audio_l_i and mb_audio_r_i in clk_pixel_w before use.
REQ-016 The module SHALL implement an FSM with states IDLE and ACTIVE plus an 8-bit hold counter, with state changes made only on ticks.
REQ-017 On a tick in IDLE: if edge_pending, then hold = HOLD_SAMPLES and the state moves to ACTIVE; otherwise no change.
REQ-018 On a tick in ACTIVE: if edge_pending, then hold reloads to HOLD_SAMPLES; else if hold > 1, then hold decrements; else hold = 0 and the state moves to IDLE.
REQ-019 The module SHALL set speaker_on = ENABLE && (state == ACTIVE) && the synchronized level, evaluated at the tick.
REQ-020 The module SHALL compute each channel as {mb, 4'b0} + (speaker_on ? SPEAKER_AMPLITUDE : 0) in 17 bits and saturate the result to 16'hFFFF.
REQ-021 The module SHALL update sample_l_o and sample_r_o at the edge one cycle after the tick, and SHALL pulse clk_audio_o high for exactly one cycle at the following edge, so that samples are stable for at least 1 cycle before the strobe.
REQ-022 The module SHALL hold sample_l_o and sample_r_o constant between updates.
REQ-023 Speaker toggles narrower than 2 clk_pixel_w cycles may be missed, and multiple toggles within one tick period SHALL produce a single reload; this is accepted behaviour.

Reset
REQ-024 While system_reset_n_w is low, all registers SHALL clear asynchronously: divider, synchronizers, edge_pending, hold = 0, state = IDLE, samples = 0, clk_audio_o = 0.
REQ-025 On reset release, the first tick SHALL occur CNT cycles later, and the first clk_audio_o SHALL occur at cycle CNT+2.
REQ-026 Reset asserted mid-ACTIVE SHALL return the block to IDLE with zero outputs, and no strobe SHALL occur during reset.

Verification
REQ-027 Reset release with no stimulus -> clk_audio_o pulses every 612 cycles starting at cycle 614; samples stay 0.
REQ-028 mb_l = 10'h3FF, mb_r = 10'h001, no toggles -> sample_l_o = 16'h3FF0 and sample_r_o = 16'h0010 from the second strobe onward.
REQ-029 Single rising toggle, held high -> the next sample equals mb<<4 + 16'h2000; the term persists for 255 ticks, then drops to mb<<4 and the FSM returns to IDLE.
REQ-030 Toggle coincident with a tick -> the speaker term appears one tick later, not lost; a toggle every 100 ticks keeps ACTIVE indefinitely.
REQ-031 SPEAKER_AMPLITUDE = 16'hF000 with mb = 10'h3FF and the speaker on -> sample saturates to 16'hFFFF; ENABLE = 0 -> sample = 16'h3FF0.
REQ-032 Reset pulsed at hold = 100 -> outputs 0 immediately, no strobe during reset, and the next strobe arrives CNT+2 cycles after release.
